multicycle_control_fsm: RTL

MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

---
 rtl/multicycle_control_fsm.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK,
// drives datapath mux selects and write enables, and traps on illegal
// opcodes or memory handshake timeouts. TIMEOUT_CYCLES must be at least 1.
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    input  logic       halt_req,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       retire,
    output logic       illegal_instr,
    output logic       bus_error,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src,
    output logic [1:0] pc_src,
    output logic [2:0] mem_to_reg,
    output logic [2:0] state
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_I      = 7'd19;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_JALR   = 7'd103;
    localparam logic [6:0] OP_LUI    = 7'd55;
    localparam logic [6:0] OP_AUIPC  = 7'd23;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_run;
    logic [6:0]    r_opcode_q;
    logic [CW-1:0] r_wait_cnt;
    logic [CW-1:0] w_wait_cnt_next;
    logic          r_illegal;
    logic          r_bus_err;
    logic          w_illegal_set;
    logic          w_timeout;
    logic          w_legal;
    logic          w_is_load;
    logic          w_is_store;
    logic          w_is_branch;
    logic          w_is_jal;
    logic          w_is_jalr;
    logic          w_is_lui;
    logic          w_is_auipc;
    logic          w_fetch_or_halt;

    // Per-type decode from the latched opcode; legality uses the live opcode in DECODE.
    always_comb begin
        w_is_load   = (r_opcode_q == OP_LOAD);
        w_is_store  = (r_opcode_q == OP_STORE);
        w_is_branch = (r_opcode_q == OP_BRANCH);
        w_is_jal    = (r_opcode_q == OP_JAL);
        w_is_jalr   = (r_opcode_q == OP_JALR);
        w_is_lui    = (r_opcode_q == OP_LUI);
        w_is_auipc  = (r_opcode_q == OP_AUIPC);
        w_legal     = (opcode == OP_R)     || (opcode == OP_I)      ||
                      (opcode == OP_LOAD)  || (opcode == OP_STORE)  ||
                      (opcode == OP_BRANCH)|| (opcode == OP_JAL)    ||
                      (opcode == OP_JALR)  || (opcode == OP_LUI)    ||
                      (opcode == OP_AUIPC);
        w_fetch_or_halt = halt_req;
        w_timeout   = (r_wait_cnt == TMO);
    end

    // Next-state and output decode; r_run holds all outputs low until the first edge after reset.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        retire        = 1'b0;
        alu_op        = 2'b00;
        alu_src       = 2'b00;
        pc_src        = 2'b00;
        mem_to_reg    = 3'b000;
        w_illegal_set = 1'b0;
        w_next_state  = r_state;

        if (!r_run) begin
            w_next_state = halt_req ? S_HALT : S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write     = 1'b1;
                        w_next_state = S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        w_next_state = S_EXECUTE;
                    end else begin
                        w_illegal_set = 1'b1;
                        w_next_state  = S_TRAP;
                    end
                end
                S_EXECUTE: begin
                    case (r_opcode_q)
                        OP_R:     begin alu_op = 2'b11; alu_src = 2'd0; end
                        OP_I:     begin alu_op = 2'b10; alu_src = 2'd1; end
                        OP_LOAD:  begin alu_op = 2'b00; alu_src = 2'd1; end
                        OP_STORE: begin alu_op = 2'b00; alu_src = 2'd2; end
                        OP_BRANCH:begin alu_op = 2'b01; alu_src = 2'd0; end
                        OP_JALR:  begin alu_op = 2'b00; alu_src = 2'd1; end
                        default:  begin alu_op = 2'b00; alu_src = 2'd0; end
                    endcase
                    if (w_is_load || w_is_store) begin
                        w_next_state = S_MEM;
                    end else if (w_is_branch) begin
                        pc_write     = 1'b1;
                        pc_src       = branch_taken ? 2'b01 : 2'b00;
                        retire       = 1'b1;
                        w_next_state = w_fetch_or_halt ? S_HALT : S_FETCH;
                    end else begin
                        w_next_state = S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = w_is_store;
                    if (mem_ready) begin
                        if (w_is_store) begin
                            pc_write     = 1'b1;
                            retire       = 1'b1;
                            w_next_state = w_fetch_or_halt ? S_HALT : S_FETCH;
                        end else begin
                            w_next_state = S_WRITEBACK;
                        end
                    end
                end
                S_WRITEBACK: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    if (w_is_jal)       pc_src = 2'b10;
                    else if (w_is_jalr) pc_src = 2'b11;
                    if (w_is_load)                mem_to_reg = 3'b001;
                    else if (w_is_jal || w_is_jalr) mem_to_reg = 3'b010;
                    else if (w_is_lui)            mem_to_reg = 3'b011;
                    else if (w_is_auipc)          mem_to_reg = 3'b100;
                    w_next_state = w_fetch_or_halt ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    if (!halt_req) w_next_state = S_FETCH;
                end
                S_TRAP: begin
                    w_next_state = S_TRAP;
                end
                default: begin
                    w_next_state = S_TRAP;
                end
            endcase

            // A timed-out handshake preempts whatever the state would have done.
            if (w_timeout) begin
                ir_write     = 1'b0;
                pc_write     = 1'b0;
                reg_write    = 1'b0;
                retire       = 1'b0;
                w_next_state = S_TRAP;
            end
        end
    end

    // Wait counter: counts stalled request cycles, saturates at the timeout value.
    always_comb begin
        if (mem_req && !mem_ready) begin
            w_wait_cnt_next = w_timeout ? r_wait_cnt : r_wait_cnt + 1'b1;
        end else begin
            w_wait_cnt_next = '0;
        end
    end

    // State, latched opcode, wait counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run      <= 1'b0;
            r_state    <= S_FETCH;
            r_opcode_q <= '0;
            r_wait_cnt <= '0;
            r_illegal  <= 1'b0;
            r_bus_err  <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            if (r_run && (r_state == S_DECODE)) r_opcode_q <= opcode;
            if (w_illegal_set) r_illegal <= 1'b1;
            if (w_wait_cnt_next == TMO) r_bus_err <= 1'b1;
        end
    end

    assign state         = r_state;
    assign illegal_instr = r_illegal;
    assign bus_error     = r_bus_err;

endmodule
